// File: rtl/verlet_node_engine.sv
// Sequenced Verlet integrator for a small set of cloth/rope nodes held in internal state RAM.
// Each frame walks every node through LOAD -> CALC -> WRITE, applying pin, mouse grab and bounds.
module verlet_node_engine #(
  parameter int NODES = 5,
  parameter int WIDTH = 32,
  parameter int FRAC = 16,
  parameter int ADDR_W = 3,
  parameter logic signed [WIDTH-1:0] GRAVITY = '0,
  parameter int DAMP_SHIFT = 0,
  parameter logic signed [WIDTH-1:0] MOUSE_R = WIDTH'(1) << FRAC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic                     mouse_en,
  input  logic signed [WIDTH-1:0]  x_mouse,
  input  logic signed [WIDTH-1:0]  y_mouse,
  input  logic signed [WIDTH-1:0]  lo_x,
  input  logic signed [WIDTH-1:0]  hi_x,
  input  logic signed [WIDTH-1:0]  lo_y,
  input  logic signed [WIDTH-1:0]  hi_y,
  input  logic [NODES-1:0]         pin_mask,
  input  logic                     init_we,
  input  logic [ADDR_W-1:0]        init_addr,
  input  logic signed [WIDTH-1:0]  init_x,
  input  logic signed [WIDTH-1:0]  init_y,
  input  logic signed [WIDTH-1:0]  init_px,
  input  logic signed [WIDTH-1:0]  init_py,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [WIDTH-1:0]  rd_x,
  output logic signed [WIDTH-1:0]  rd_y
);

  localparam int XW = WIDTH + 2;
  localparam logic [ADDR_W:0]      NODE_CNT = (ADDR_W+1)'(NODES);
  localparam logic [ADDR_W-1:0]    LAST_IDX = ADDR_W'(NODES - 1);
  localparam logic signed [XW-1:0] SAT_MAX  = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN  = {3'b111, {(WIDTH-1){1'b0}}};

  typedef logic signed [WIDTH-1:0] word_t;
  typedef logic signed [XW-1:0]    wide_t;
  typedef struct packed { logic hit; word_t val; } clamp_t;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_WRITE, S_DONE} state_t;

  function automatic wide_t sx(input word_t a);
    return {{2{a[WIDTH-1]}}, a};
  endfunction

  // Verlet step on one axis with optional damping, saturated back to WIDTH.
  function automatic word_t step(input word_t cur, input word_t prev, input word_t grav);
    wide_t v;
    wide_t n;
    v = sx(cur) - sx(prev);
    if (DAMP_SHIFT != 0) v = v - (v >>> DAMP_SHIFT);
    n = sx(cur) + v + sx(grav);
    if (n > SAT_MAX) return SAT_MAX[WIDTH-1:0];
    if (n < SAT_MIN) return SAT_MIN[WIDTH-1:0];
    return n[WIDTH-1:0];
  endfunction

  // hi first, then lo, so lo wins when the window is inverted.
  function automatic clamp_t clamp(input word_t n, input word_t lo, input word_t hi);
    word_t  c;
    logic   h;
    clamp_t r;
    c = n;
    h = 1'b0;
    if (n > hi) begin c = hi; h = 1'b1; end
    if (c < lo) begin c = lo; h = 1'b1; end
    r.hit = h;
    r.val = c;
    return r;
  endfunction

  function automatic logic near(input word_t a, input word_t m);
    wide_t d;
    d = sx(a) - sx(m);
    if (d[XW-1]) d = -d;
    return d < sx(MOUSE_R);
  endfunction

  state_t state, state_nx;
  logic [ADDR_W-1:0] idx;
  word_t mem_x [NODES];
  word_t mem_y [NODES];
  word_t mem_px [NODES];
  word_t mem_py [NODES];
  word_t c_x, c_y, p_x, p_y;
  word_t n_x, n_y, np_x, np_y;
  word_t nx, ny, npx, npy;
  clamp_t cx_c, cy_c;
  logic rd_ok, init_ok;

  assign rd_ok   = {1'b0, rd_addr} < NODE_CNT;
  assign init_ok = init_we && ({1'b0, init_addr} < NODE_CNT) && (state == S_IDLE || state == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      idx   <= '0;
      rd_x  <= '0;
      rd_y  <= '0;
    end else begin
      state <= state_nx;
      if (state == S_WRITE) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      rd_x <= rd_ok ? mem_x[rd_addr] : '0;
      rd_y <= rd_ok ? mem_y[rd_addr] : '0;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_CALC;
      S_CALC:  state_nx = S_WRITE;
      S_WRITE: state_nx = (idx == LAST_IDX) ? S_DONE : S_LOAD;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_LOAD) || (state == S_CALC) || (state == S_WRITE);
    done = (state == S_DONE);
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cx_c = clamp(step(c_x, p_x, '0), lo_x, hi_x);
    cy_c = clamp(step(c_y, p_y, GRAVITY), lo_y, hi_y);
    nx   = cx_c.val;
    ny   = cy_c.val;
    npx  = cx_c.hit ? cx_c.val : c_x;
    npy  = cy_c.hit ? cy_c.val : c_y;
    if (pin_mask[idx]) begin
      nx  = c_x;
      ny  = c_y;
      npx = p_x;
      npy = p_y;
    end else if (mouse_en && near(c_x, x_mouse) && near(c_y, y_mouse)) begin
      nx  = x_mouse;
      ny  = y_mouse;
      npx = x_mouse;
      npy = y_mouse;
    end
  end

  // NOTE: node RAM and datapath registers carry no reset; node state survives a reset by design.
  always_ff @(posedge clk) begin
    case (state)
      S_LOAD: begin
        c_x <= mem_x[idx];
        c_y <= mem_y[idx];
        p_x <= mem_px[idx];
        p_y <= mem_py[idx];
      end
      S_CALC: begin
        n_x  <= nx;
        n_y  <= ny;
        np_x <= npx;
        np_y <= npy;
      end
      default: ;
    endcase
    if (state == S_WRITE) begin
      mem_x[idx]  <= n_x;
      mem_y[idx]  <= n_y;
      mem_px[idx] <= np_x;
      mem_py[idx] <= np_y;
    end else if (init_ok) begin
      mem_x[init_addr]  <= init_x;
      mem_y[init_addr]  <= init_y;
      mem_px[init_addr] <= init_px;
      mem_py[init_addr] <= init_py;
    end
  end

endmodule
